// File: rtl/sif_pkg.sv
// Shared constants, types and address decoding for the sif storage interface.
// Both ports decode through addr_decode so the X and W windows always agree.
package sif_pkg;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int DEPTH   = 256;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int WIN_BIT = AW - 1;

    typedef struct packed {
        logic             hit_x;
        logic             hit_w;
        logic [IDX_W-1:0] idx;
    } decode_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_X    = 2'd1,
        SEL_W    = 2'd2
    } rd_sel_e;

    // Bits between the window bit and the index must be zero for a hit.
    function automatic decode_t addr_decode(input logic [AW-1:0] addr);
        decode_t d;
        logic    in_range;
        in_range = (addr[WIN_BIT-1:IDX_W] == '0);
        d.hit_x  = in_range && !addr[WIN_BIT];
        d.hit_w  = in_range && addr[WIN_BIT];
        d.idx    = addr[IDX_W-1:0];
        return d;
    endfunction

endpackage

// File: rtl/sif_regbank.sv
// DEPTH x DW storage bank with one write port and one registered read port.
// Reads sample the array before the same-edge write lands, so they return old data.
module sif_regbank
    import sif_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [DW-1:0]    wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [DW-1:0]    rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // rd_data holds between reads; only a new read or reset changes it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/sif.sv
// Dual-port storage interface: X port reads/writes the X bank and reads the W bank
// through its upper window; W port only writes the W bank.
module sif
    import sif_pkg::*;
(
    input  logic          clk,
    input  logic          rst_b,
    input  logic          xa_wr_s,
    input  logic          xa_rd_s,
    input  logic [AW-1:0] xa_addr,
    input  logic [DW-1:0] xa_data_wr,
    output logic [DW-1:0] xa_data_rd,
    input  logic          wa_wr_s,
    input  logic [AW-1:0] wa_addr,
    input  logic [DW-1:0] wa_data_wr
);

    decode_t       x_dec;
    decode_t       w_dec;
    logic          w_in_range;
    logic [DW-1:0] x_bank_rd;
    logic [DW-1:0] w_bank_rd;
    rd_sel_e       rd_sel;

    // The W port ignores the window bit, so a hit on either side means in range.
    assign x_dec      = addr_decode(xa_addr);
    assign w_dec      = addr_decode(wa_addr);
    assign w_in_range = w_dec.hit_x | w_dec.hit_w;

    sif_regbank u_x_bank (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en   (xa_wr_s & x_dec.hit_x),
        .wr_idx  (x_dec.idx),
        .wr_data (xa_data_wr),
        .rd_en   (xa_rd_s & x_dec.hit_x),
        .rd_idx  (x_dec.idx),
        .rd_data (x_bank_rd)
    );

    sif_regbank u_w_bank (
        .clk     (clk),
        .rst_b   (rst_b),
        .wr_en   (wa_wr_s & w_in_range),
        .wr_idx  (w_dec.idx),
        .wr_data (wa_data_wr),
        .rd_en   (xa_rd_s & x_dec.hit_w),
        .rd_idx  (x_dec.idx),
        .rd_data (w_bank_rd)
    );

    // The select remembers which bank the last read targeted, so the output holds.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_sel <= SEL_NONE;
        end else if (xa_rd_s) begin
            if (x_dec.hit_x) begin
                rd_sel <= SEL_X;
            end else if (x_dec.hit_w) begin
                rd_sel <= SEL_W;
            end else begin
                rd_sel <= SEL_NONE;
            end
        end
    end

    always_comb begin
        xa_data_rd = '0;
        case (rd_sel)
            SEL_X:   xa_data_rd = x_bank_rd;
            SEL_W:   xa_data_rd = w_bank_rd;
            default: xa_data_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_sif.sv
// Self-checking bench for sif: directed vectors with literal expectations plus a
// per-cycle comparison against an address-arithmetic model of both buffers.
module tb_sif;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        xa_wr_s = 1'b0;
    logic        xa_rd_s = 1'b0;
    logic [15:0] xa_addr = '0;
    logic [15:0] xa_data_wr = '0;
    logic [15:0] xa_data_rd;
    logic        wa_wr_s = 1'b0;
    logic [15:0] wa_addr = '0;
    logic [15:0] wa_data_wr = '0;

    int total = 0;
    int bad = 0;
    logic check_en = 1'b0;

    logic [15:0] xm [256];
    logic [15:0] wm [256];
    logic [15:0] model_rd;

    sif dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .xa_wr_s    (xa_wr_s),
        .xa_rd_s    (xa_rd_s),
        .xa_addr    (xa_addr),
        .xa_data_wr (xa_data_wr),
        .xa_data_rd (xa_data_rd),
        .wa_wr_s    (wa_wr_s),
        .wa_addr    (wa_addr),
        .wa_data_wr (wa_data_wr)
    );

    always #5 clk = ~clk;

    // X space is 0x0000-0x00FF, W window 0x8000-0x80FF; anything else reads 0.
    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (a < 16'h0100) return xm[a[7:0]];
        if (a >= 16'h8000 && a < 16'h8100) return wm[a[7:0]];
        return 16'h0000;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 256; i++) begin
                xm[i] <= 16'h0000;
                wm[i] <= 16'h0000;
            end
            model_rd <= 16'h0000;
        end else begin
            if (xa_rd_s) model_rd <= model_read(xa_addr);
            if (xa_wr_s && xa_addr < 16'h0100) xm[xa_addr[7:0]] <= xa_data_wr;
            if (wa_wr_s && (wa_addr & 16'h7FFF) < 16'h0100) wm[wa_addr[7:0]] <= wa_data_wr;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if (xa_data_rd !== model_rd) begin
                bad++;
                $display("[TB] FAIL model_cmp t=%0t got=%h want=%h", $time, xa_data_rd, model_rd);
            end
        end
    end

    task automatic apply_stimulus(input logic x_wr, input logic x_rd, input logic [15:0] x_addr,
                                  input logic [15:0] x_data, input logic w_wr,
                                  input logic [15:0] w_addr, input logic [15:0] w_data);
        xa_wr_s    = x_wr;
        xa_rd_s    = x_rd;
        xa_addr    = x_addr;
        xa_data_wr = x_data;
        wa_wr_s    = w_wr;
        wa_addr    = w_addr;
        wa_data_wr = w_data;
        @(posedge clk);
        #1;
        xa_wr_s = 1'b0;
        xa_rd_s = 1'b0;
        wa_wr_s = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [15:0] want);
        total++;
        if (xa_data_rd !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, xa_data_rd, want);
        end
    endtask

    task automatic x_write(input logic [15:0] a, input logic [15:0] d);
        apply_stimulus(1'b1, 1'b0, a, d, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic x_read(input logic [15:0] a);
        apply_stimulus(1'b0, 1'b1, a, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic w_write(input logic [15:0] a, input logic [15:0] d);
        apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, a, d);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_hold", 16'h0000);
        rst_b = 1'b1;
        check_en = 1'b1;

        x_read(16'h0000);  check_output("rst_x0", 16'h0000);
        x_read(16'h00FF);  check_output("rst_x255", 16'h0000);
        x_read(16'h8000);  check_output("rst_w0", 16'h0000);

        x_write(16'h0005, 16'h1234);
        x_read(16'h0005);  check_output("x_rd5", 16'h1234);
        x_write(16'h00FF, 16'hBEEF);
        x_read(16'h00FF);  check_output("x_rd255", 16'hBEEF);
        repeat (3) @(posedge clk);
        #1;
        check_output("hold_idle", 16'hBEEF);

        w_write(16'h0010, 16'hA5A5);
        x_read(16'h8010);  check_output("w_win", 16'hA5A5);
        x_write(16'h8010, 16'hFFFF);
        x_read(16'h8010);  check_output("w_win_ro", 16'hA5A5);
        x_read(16'h0010);  check_output("x10_clean", 16'h0000);

        x_write(16'h0003, 16'h1111);
        apply_stimulus(1'b1, 1'b1, 16'h0003, 16'h2222, 1'b0, 16'h0, 16'h0);
        check_output("rbw_old", 16'h1111);
        x_read(16'h0003);  check_output("rbw_new", 16'h2222);

        apply_stimulus(1'b0, 1'b1, 16'h8020, 16'h0, 1'b1, 16'h8020, 16'h7777);
        check_output("w_rbw_old", 16'h0000);
        x_read(16'h8020);  check_output("w_rbw_new", 16'h7777);

        apply_stimulus(1'b1, 1'b0, 16'h0040, 16'h0A0A, 1'b1, 16'h0040, 16'h0B0B);
        x_read(16'h0040);  check_output("dual_x", 16'h0A0A);
        x_read(16'h8040);  check_output("dual_w", 16'h0B0B);

        x_write(16'h0105, 16'h5555);
        x_read(16'h0105);  check_output("oor_rd", 16'h0000);
        x_read(16'h0005);  check_output("oor_x5", 16'h1234);
        w_write(16'h0210, 16'h9999);
        x_read(16'h8010);  check_output("w_oor", 16'hA5A5);

        x_read(16'h0005);
        x_read(16'h8010);  check_output("b2b_w", 16'hA5A5);
        x_read(16'h00FF);  check_output("b2b_x", 16'hBEEF);

        for (int i = 0; i < 16; i++) begin
            x_write(16'(i), 16'(i * 16'h0101));
        end
        for (int i = 0; i < 8; i++) begin
            x_read(16'(i));
            check_output("burst", 16'(i * 16'h0101));
        end
        xa_rd_s = 1'b1;
        xa_addr = 16'h0008;
        #2;
        rst_b = 1'b0;
        #1;
        check_output("rst_mid", 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        xa_rd_s = 1'b0;
        check_output("rst_mid_hold", 16'h0000);
        rst_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x_read(16'(i));
            check_output("post_rst", 16'h0000);
        end
        x_read(16'h8020);  check_output("post_rst_w", 16'h0000);

        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
